// File: rtl/stream_framer_pkg.sv
// ============================================================================
// Module      : stream_framer_pkg
// Description : Shared types and constants for the stream_framer block.
//               The err_cnt width below is used only when the
//               STREAM_FRAMER_ERR_CNT_EN macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_framer_pkg;

  // Framer control states
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Width of the optional error counter
  localparam int ERR_CNT_W = 16;

  // Counter width for a dimension of n elements (never below 1 bit)
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_framer_if.sv
// ============================================================================
// Module      : stream_framer_if
// Description : Pixel stream bundle around the framer: raw pixel input with
//               frame arm pulse, framed pixel output with sop/eop, status.
//               master = pixel source / sink side, slave = framer side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stream_framer_if #(
  parameter int DW = 1
);
  logic          frame_start;
  logic [DW-1:0] din;
  logic          din_vld;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic          dout_sop;
  logic          dout_eop;
  logic          busy;
  logic          err_short;

  modport master (
    output frame_start, din, din_vld,
    input  dout, dout_vld, dout_sop, dout_eop, busy, err_short
  );

  modport slave (
    input  frame_start, din, din_vld,
    output dout, dout_vld, dout_sop, dout_eop, busy, err_short
  );
endinterface

`default_nettype wire

// File: rtl/stream_framer_pix_counter.sv
// ============================================================================
// Module      : pix_counter
// Description : Column/row position counter for one image frame. Wraps the
//               column at IMG_W-1 into the next row and the row at IMG_H-1
//               back to the origin. Clear has priority; clear together with
//               enable lands on column 1 (pixel 0 consumed in the same cycle).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pix_counter
  import stream_framer_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic first_o,
  output logic last_o
);

  localparam int CW = cnt_width(IMG_W);
  localparam int RW = cnt_width(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // Next position: clear, or advance with explicit wrap at row/frame end
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = en_i ? CW'(1) : '0;
      row_d = '0;
    end else if (en_i) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Position registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign first_o = (col_q == '0) && (row_q == '0);
  assign last_o  = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

`default_nettype wire

// File: rtl/stream_framer.sv
// ============================================================================
// Module      : stream_framer
// Description : Packetizes a raw pixel stream into frames of IMG_W x IMG_H
//               pixels with sop/eop markers, 1-cycle registered latency.
//               A frame_start while a frame is partially received aborts it
//               and pulses err_short. Optional macro STREAM_FRAMER_ERR_CNT_EN
//               adds a saturating err_cnt output (aborts + dropped pixels).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_framer
  import stream_framer_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int DW    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  stream_framer_if.slave       bus
`ifdef STREAM_FRAMER_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  state_e        state_q;
  logic [DW-1:0] dout_q;
  logic          dout_vld_q;
  logic          dout_sop_q;
  logic          dout_eop_q;
  logic          busy_q;
  logic          err_short_q;

  logic          cnt_first;
  logic          cnt_last;
  logic          active;
  logic          pix_acc;
  logic          abort;
  logic          drop;

  // A pixel is taken when a frame is running or is being armed this cycle;
  // frame_start always wins, so a coincident pixel becomes index 0.
  assign active  = (state_q == ACTIVE);
  assign pix_acc = bus.din_vld && (bus.frame_start || active);
  assign abort   = bus.frame_start && active && !cnt_first;
  assign drop    = bus.din_vld && !bus.frame_start && !active;

  pix_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_pix_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (pix_acc),
    .clr_i   (bus.frame_start),
    .first_o (cnt_first),
    .last_o  (cnt_last)
  );

  // Control FSM with registered framed outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      dout_sop_q  <= 1'b0;
      dout_eop_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_short_q <= 1'b0;
    end else begin
      dout_vld_q  <= pix_acc;
      dout_sop_q  <= pix_acc && (bus.frame_start || cnt_first);
      dout_eop_q  <= pix_acc && !bus.frame_start && cnt_last;
      err_short_q <= abort;
      if (pix_acc) begin
        dout_q <= bus.din;
      end
      case (state_q)
        IDLE: begin
          if (bus.frame_start) begin
            state_q <= ACTIVE;
            busy_q  <= 1'b1;
          end
        end
        ACTIVE: begin
          if (!bus.frame_start && pix_acc && cnt_last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout      = dout_q;
  assign bus.dout_vld  = dout_vld_q;
  assign bus.dout_sop  = dout_sop_q;
  assign bus.dout_eop  = dout_eop_q;
  assign bus.busy      = busy_q;
  assign bus.err_short = err_short_q;

`ifdef STREAM_FRAMER_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // Saturating count of aborted frames and pixels dropped while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if ((abort || drop) && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`else
  // Dropped pixels only matter to the optional counter
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

`default_nettype wire
